sprite_anim_sequencer: RTL and testbench

SPRITE_ANIM_SEQUENCER -- requirements
Module: sprite_anim_sequencer

---
 rtl/sprite_anim_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_sprite_anim_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_sequencer.sv
// Purpose: per-entity sprite pose sequencer (player + 4 enemies) producing sprite-sheet origins.
// Latency: 1 clk; the pose selected on a frame_tick edge is visible in the following cycle.
// Backpressure: none; the block advances only on frame_tick and otherwise holds every output.
//
// Ports:
//   clk, rst_n              sole clock, synchronous active-low reset
//   frame_tick              one-cycle pulse per video frame
//   move_req/attack_req/shield_req/dead/dir [4:0]   bit 0 = player, bits 1..4 = enemies 0..3
//   sprite_x0..4/sprite_y0..4 [9:0]                 registered sprite-sheet origin per entity
//   attack_active, hit_pulse [4:0], all_dead        registered status
// Build option: define SPRITE_WALK_ANIM_EN to animate WALK across columns 40/80/120;
// without it WALK shows column 40 only and the walk column index is not built.
module sprite_anim_sequencer #(
    parameter int ATTACK_FRAMES = 8,
    parameter int HIT_FRAME     = 3,
    parameter int WALK_FRAMES   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [4:0] move_req,
    input  logic [4:0] attack_req,
    input  logic [4:0] shield_req,
    input  logic [4:0] dead,
    input  logic [4:0] dir,
    output logic [9:0] sprite_x0,
    output logic [9:0] sprite_x1,
    output logic [9:0] sprite_x2,
    output logic [9:0] sprite_x3,
    output logic [9:0] sprite_x4,
    output logic [9:0] sprite_y0,
    output logic [9:0] sprite_y1,
    output logic [9:0] sprite_y2,
    output logic [9:0] sprite_y3,
    output logic [9:0] sprite_y4,
    output logic [4:0] attack_active,
    output logic [4:0] hit_pulse,
    output logic       all_dead
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK,
        ST_ATTACK,
        ST_SHIELD,
        ST_DEAD
    } state_t;

    localparam logic [3:0] ATK_LAST = 4'(ATTACK_FRAMES - 1);
    localparam logic [3:0] HIT_CNT  = 4'(HIT_FRAME);
`ifdef SPRITE_WALK_ANIM_EN
    localparam logic [3:0] WALK_LAST = 4'(WALK_FRAMES - 1);
`endif

    state_t     st_q   [5];
    state_t     st_d   [5];
    logic [3:0] cnt_q  [5];
    logic [3:0] cnt_d  [5];
    logic       face_q [5];
    logic       face_d [5];
    logic [9:0] x_q    [5];
    logic [9:0] x_d    [5];
    logic [9:0] y_q    [5];
    logic [9:0] y_d    [5];
    logic [4:0] hit_d;
    logic       all_dead_d;
`ifdef SPRITE_WALK_ANIM_EN
    logic [1:0] widx_q [5];
    logic [1:0] widx_d [5];
`endif

    // Next-state and next-pose for every entity. cnt doubles as the attack
    // frame counter and (when animated) the walk column tick counter.
    always_comb begin
        hit_d = '0;
        for (int e = 0; e < 5; e++) begin
            st_d[e]   = st_q[e];
            cnt_d[e]  = cnt_q[e];
            face_d[e] = face_q[e];
`ifdef SPRITE_WALK_ANIM_EN
            widx_d[e] = widx_q[e];
`endif
            if (dead[e]) begin
                st_d[e]  = ST_DEAD;
                cnt_d[e] = 4'd0;
            end else if (st_q[e] == ST_DEAD) begin
                // Leaving DEAD always lands in IDLE, requests are ignored this tick.
                st_d[e]  = ST_IDLE;
                cnt_d[e] = 4'd0;
            end else if (st_q[e] == ST_ATTACK && cnt_q[e] != ATK_LAST) begin
                // Attack in progress: locked against requests and dir.
                cnt_d[e] = cnt_q[e] + 4'd1;
                hit_d[e] = ((cnt_q[e] + 4'd1) == HIT_CNT);
            end else begin
                face_d[e] = dir[e];
                cnt_d[e]  = 4'd0;
                if (attack_req[e]) begin
                    st_d[e] = ST_ATTACK;
                end else if (shield_req[e]) begin
                    st_d[e] = ST_SHIELD;
                end else if (move_req[e]) begin
                    st_d[e] = ST_WALK;
`ifdef SPRITE_WALK_ANIM_EN
                    if (st_q[e] == ST_WALK) begin
                        if (cnt_q[e] == WALK_LAST) begin
                            widx_d[e] = (widx_q[e] == 2'd2) ? 2'd0 : widx_q[e] + 2'd1;
                        end else begin
                            cnt_d[e] = cnt_q[e] + 4'd1;
                        end
                    end else begin
                        widx_d[e] = 2'd0;
                    end
`endif
                end else begin
                    st_d[e] = ST_IDLE;
                end
            end

            case (st_d[e])
                ST_IDLE:   x_d[e] = 10'd0;
`ifdef SPRITE_WALK_ANIM_EN
                ST_WALK:   x_d[e] = 10'd40 + 10'd40 * 10'(widx_d[e]);
`else
                ST_WALK:   x_d[e] = 10'd40;
`endif
                ST_ATTACK: x_d[e] = 10'd160;
                ST_SHIELD: x_d[e] = 10'd200;
                default:   x_d[e] = 10'd40;
            endcase

            if (st_d[e] == ST_DEAD) begin
                y_d[e] = 10'd240;
            end else if (e == 0) begin
                y_d[e] = face_d[e] ? 10'd0 : 10'd60;
            end else begin
                y_d[e] = face_d[e] ? 10'd120 : 10'd180;
            end
        end
        all_dead_d = (st_d[1] == ST_DEAD) && (st_d[2] == ST_DEAD) &&
                     (st_d[3] == ST_DEAD) && (st_d[4] == ST_DEAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < 5; e++) begin
                st_q[e]   <= ST_IDLE;
                cnt_q[e]  <= 4'd0;
                face_q[e] <= 1'b1;
                x_q[e]    <= 10'd0;
                y_q[e]    <= (e == 0) ? 10'd0 : 10'd120;
`ifdef SPRITE_WALK_ANIM_EN
                widx_q[e] <= 2'd0;
`endif
            end
            attack_active <= '0;
            hit_pulse     <= '0;
            all_dead      <= 1'b0;
        end else begin
            // hit_pulse is a one-cycle strobe, so it clears on every non-tick cycle.
            hit_pulse <= '0;
            if (frame_tick) begin
                for (int e = 0; e < 5; e++) begin
                    st_q[e]          <= st_d[e];
                    cnt_q[e]         <= cnt_d[e];
                    face_q[e]        <= face_d[e];
                    x_q[e]           <= x_d[e];
                    y_q[e]           <= y_d[e];
                    attack_active[e] <= (st_d[e] == ST_ATTACK);
`ifdef SPRITE_WALK_ANIM_EN
                    widx_q[e]        <= widx_d[e];
`endif
                end
                hit_pulse <= hit_d;
                all_dead  <= all_dead_d;
            end
        end
    end

    assign sprite_x0 = x_q[0];
    assign sprite_x1 = x_q[1];
    assign sprite_x2 = x_q[2];
    assign sprite_x3 = x_q[3];
    assign sprite_x4 = x_q[4];
    assign sprite_y0 = y_q[0];
    assign sprite_y1 = y_q[1];
    assign sprite_y2 = y_q[2];
    assign sprite_y3 = y_q[3];
    assign sprite_y4 = y_q[4];

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Purpose: self-checking bench for sprite_anim_sequencer (table vectors, directed corners, random vs model).
// Latency: expects each tick's pose one cycle after the tick edge.
// Backpressure: n/a; stimulus driven on the falling edge, outputs sampled on the next falling edge.
module tb_sprite_anim_sequencer;

    localparam int AF = 8;
    localparam int HF = 3;
    localparam int WF = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [4:0] move_req = '0, attack_req = '0, shield_req = '0, dead = '0, dir = '1;
    logic [9:0] sprite_x0, sprite_x1, sprite_x2, sprite_x3, sprite_x4;
    logic [9:0] sprite_y0, sprite_y1, sprite_y2, sprite_y3, sprite_y4;
    logic [4:0] attack_active, hit_pulse;
    logic       all_dead;

    int n_vec = 0;
    int n_bad = 0;

    sprite_anim_sequencer #(.ATTACK_FRAMES(AF), .HIT_FRAME(HF), .WALK_FRAMES(WF)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_req(move_req), .attack_req(attack_req), .shield_req(shield_req),
        .dead(dead), .dir(dir),
        .sprite_x0(sprite_x0), .sprite_x1(sprite_x1), .sprite_x2(sprite_x2),
        .sprite_x3(sprite_x3), .sprite_x4(sprite_x4),
        .sprite_y0(sprite_y0), .sprite_y1(sprite_y1), .sprite_y2(sprite_y2),
        .sprite_y3(sprite_y3), .sprite_y4(sprite_y4),
        .attack_active(attack_active), .hit_pulse(hit_pulse), .all_dead(all_dead)
    );

    always #5 clk = ~clk;

    logic [9:0] sx [5];
    logic [9:0] sy [5];
    assign sx[0] = sprite_x0; assign sx[1] = sprite_x1; assign sx[2] = sprite_x2;
    assign sx[3] = sprite_x3; assign sx[4] = sprite_x4;
    assign sy[0] = sprite_y0; assign sy[1] = sprite_y1; assign sy[2] = sprite_y2;
    assign sy[3] = sprite_y3; assign sy[4] = sprite_y4;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 walk, 2 attack, 3 shield, 4 dead; age = ticks spent in the mode.
    int m_mode [5];
    int m_age  [5];
    bit m_face [5];
    bit m_hit  [5];

    function automatic void model_reset();
        for (int e = 0; e < 5; e++) begin
            m_mode[e] = 0; m_age[e] = 0; m_face[e] = 1'b1; m_hit[e] = 1'b0;
        end
    endfunction

    function automatic void model_tick();
        int nm;
        for (int e = 0; e < 5; e++) begin
            m_hit[e] = 1'b0;
            if (dead[e]) begin
                m_mode[e] = 4; m_age[e] = 0;
            end else if (m_mode[e] == 4) begin
                m_mode[e] = 0; m_age[e] = 0;
            end else if (m_mode[e] == 2 && m_age[e] < AF - 1) begin
                m_age[e]++;
                m_hit[e] = (m_age[e] == HF);
            end else begin
                m_face[e] = dir[e];
                nm = attack_req[e] ? 2 : shield_req[e] ? 3 : move_req[e] ? 1 : 0;
                m_age[e] = (nm == 1 && m_mode[e] == 1) ? m_age[e] + 1 : 0;
                m_mode[e] = nm;
            end
        end
    endfunction

    function automatic logic [127:0] model_bundle();
        logic [9:0] ex [5];
        logic [9:0] ey [5];
        logic [4:0] ea, eh;
        for (int e = 0; e < 5; e++) begin
            case (m_mode[e])
                0: ex[e] = 10'd0;
`ifdef SPRITE_WALK_ANIM_EN
                1: ex[e] = 10'(40 + 40 * ((m_age[e] / WF) % 3));
`else
                1: ex[e] = 10'd40;
`endif
                2: ex[e] = 10'd160;
                3: ex[e] = 10'd200;
                default: ex[e] = 10'd40;
            endcase
            if (m_mode[e] == 4)  ey[e] = 10'd240;
            else if (e == 0)     ey[e] = m_face[e] ? 10'd0 : 10'd60;
            else                 ey[e] = m_face[e] ? 10'd120 : 10'd180;
            ea[e] = (m_mode[e] == 2);
            eh[e] = m_hit[e];
        end
        return {17'd0, ex[0], ex[1], ex[2], ex[3], ex[4], ey[0], ey[1], ey[2], ey[3], ey[4],
                ea, eh, (m_mode[1] == 4 && m_mode[2] == 4 && m_mode[3] == 4 && m_mode[4] == 4)};
    endfunction

    function automatic logic [127:0] dut_bundle();
        return {17'd0, sprite_x0, sprite_x1, sprite_x2, sprite_x3, sprite_x4,
                sprite_y0, sprite_y1, sprite_y2, sprite_y3, sprite_y4,
                attack_active, hit_pulse, all_dead};
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bundle(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: inputs already set; sample after the next falling edge.
    task automatic cyc(input logic tk);
        frame_tick = tk;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; frame_tick = 1'b0;
        move_req = '0; attack_req = '0; shield_req = '0; dead = '0; dir = '1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        for (int e = 0; e < 5; e++) begin
            chk($sformatf("%s x%0d", tag, e), int'(sx[e]), 0);
            chk($sformatf("%s y%0d", tag, e), int'(sy[e]), (e == 0) ? 0 : 120);
        end
        chk({tag, " attack_active"}, int'(attack_active), 0);
        chk({tag, " hit_pulse"}, int'(hit_pulse), 0);
        chk({tag, " all_dead"}, int'(all_dead), 0);
    endtask

    // ---------------- player vector table ----------------
    typedef struct {
        logic       tk, a, s, m, d;
        logic [9:0] ex, ey;
        logic       eh, ea;
    } vec_t;

    function automatic vec_t mk(logic tk, logic a, logic s, logic m, logic d,
                                int ex, int ey, logic eh, logic ea);
        vec_t v;
        v.tk = tk; v.a = a; v.s = s; v.m = m; v.d = d;
        v.ex = 10'(ex); v.ey = 10'(ey); v.eh = eh; v.ea = ea;
        return v;
    endfunction

    vec_t tbl [15];
    logic [127:0] snap;
    int exp_walk;

    initial begin
        // tick atk shd mov dir   x    y  hit act
        tbl[0]  = mk(1, 1, 0, 0, 1, 160,  0, 0, 1);  // attack starts, counter 0
        tbl[1]  = mk(1, 0, 0, 0, 1, 160,  0, 0, 1);  // 1
        tbl[2]  = mk(1, 0, 0, 0, 1, 160,  0, 0, 1);  // 2
        tbl[3]  = mk(1, 0, 0, 0, 1, 160,  0, 1, 1);  // 3 = hit frame
        tbl[4]  = mk(0, 0, 0, 0, 1, 160,  0, 0, 1);  // no tick: held, strobe gone
        tbl[5]  = mk(1, 0, 0, 0, 1, 160,  0, 0, 1);  // 4
        tbl[6]  = mk(1, 0, 0, 0, 1, 160,  0, 0, 1);  // 5
        tbl[7]  = mk(1, 0, 0, 0, 1, 160,  0, 0, 1);  // 6
        tbl[8]  = mk(1, 0, 0, 0, 1, 160,  0, 0, 1);  // 7 = last
        tbl[9]  = mk(1, 0, 0, 0, 1,   0,  0, 0, 0);  // back to idle
        tbl[10] = mk(1, 0, 0, 1, 1,  40,  0, 0, 0);  // walk
        tbl[11] = mk(1, 0, 1, 1, 1, 200,  0, 0, 0);  // shield beats move
        tbl[12] = mk(1, 0, 0, 1, 0,  40, 60, 0, 0);  // walk facing left
        tbl[13] = mk(1, 1, 1, 0, 0, 160, 60, 0, 1);  // attack beats shield
        tbl[14] = mk(1, 1, 0, 0, 1, 160, 60, 0, 1);  // dir ignored mid-attack

        do_reset();
        chk_reset("reset");

        for (int i = 0; i < 15; i++) begin
            attack_req[0] = tbl[i].a; shield_req[0] = tbl[i].s;
            move_req[0] = tbl[i].m;   dir[0] = tbl[i].d;
            cyc(tbl[i].tk);
            chk($sformatf("tbl[%0d] x0", i), int'(sprite_x0), int'(tbl[i].ex));
            chk($sformatf("tbl[%0d] y0", i), int'(sprite_y0), int'(tbl[i].ey));
            chk($sformatf("tbl[%0d] hit0", i), int'(hit_pulse[0]), int'(tbl[i].eh));
            chk($sformatf("tbl[%0d] act0", i), int'(attack_active[0]), int'(tbl[i].ea));
        end

        // Walk column sequence over 20 ticks.
        do_reset();
        move_req[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1);
`ifdef SPRITE_WALK_ANIM_EN
            exp_walk = (i < 6) ? 40 : (i < 12) ? 80 : (i < 18) ? 120 : 40;
`else
            exp_walk = 40;
`endif
            chk($sformatf("walk tick %0d x0", i), int'(sprite_x0), exp_walk);
        end

        // Enemy 2 locked in attack while dir and shield change.
        do_reset();
        attack_req[3] = 1'b1;
        cyc(1'b1);
        attack_req[3] = 1'b0; dir[3] = 1'b0; shield_req[3] = 1'b1;
        for (int i = 1; i < AF; i++) begin
            cyc(1'b1);
            chk($sformatf("lock tick %0d x3", i), int'(sprite_x3), 160);
            chk($sformatf("lock tick %0d y3", i), int'(sprite_y3), 120);
        end
        cyc(1'b1);
        chk("lock end x3", int'(sprite_x3), 200);
        chk("lock end y3", int'(sprite_y3), 180);

        // Enemy 0 killed before its hit frame.
        do_reset();
        attack_req[1] = 1'b1;
        cyc(1'b1);
        attack_req[1] = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        dead[1] = 1'b1;
        cyc(1'b1);
        chk("kill x1", int'(sprite_x1), 40);
        chk("kill y1", int'(sprite_y1), 240);
        chk("kill act1", int'(attack_active[1]), 0);
        chk("kill hit1", int'(hit_pulse[1]), 0);
        cyc(1'b0);
        chk("kill hold hit1", int'(hit_pulse[1]), 0);
        dead[1] = 1'b0;
        cyc(1'b1);
        chk("revive x1", int'(sprite_x1), 0);
        chk("revive y1", int'(sprite_y1), 120);

        // all_dead and reset in the middle of an attack.
        do_reset();
        dead = 5'b11110;
        cyc(1'b0);
        chk("all_dead before tick", int'(all_dead), 0);
        cyc(1'b1);
        chk("all_dead after tick", int'(all_dead), 1);
        attack_req[0] = 1'b1;
        cyc(1'b1);
        attack_req[0] = 1'b0;
        cyc(1'b1);
        chk("pre-reset act0", int'(attack_active[0]), 1);
        rst_n = 1'b0;
        cyc(1'b0);
        chk_reset("mid-attack reset");
        rst_n = 1'b1;

        // Random phase against the model, then a long no-tick hold.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            frame_tick = 1'($urandom_range(0, 1));
            for (int e = 0; e < 5; e++) begin
                attack_req[e] = ($urandom_range(0, 5) == 0);
                shield_req[e] = ($urandom_range(0, 3) == 0);
                move_req[e]   = ($urandom_range(0, 1) == 0);
                dir[e]        = ($urandom_range(0, 3) != 0) ? dir[e] : ~dir[e];
                if ($urandom_range(0, 19) == 0) dead[e] = ~dead[e];
            end
            @(posedge clk);
            if (frame_tick) model_tick();
            else for (int e = 0; e < 5; e++) m_hit[e] = 1'b0;
            @(negedge clk);
            chk_bundle("random", dut_bundle(), model_bundle());
        end

        frame_tick = 1'b0;
        cyc(1'b0);
        for (int e = 0; e < 5; e++) m_hit[e] = 1'b0;
        snap = model_bundle();
        for (int c = 0; c < 1000; c++) begin
            attack_req = 5'($urandom); shield_req = 5'($urandom);
            move_req = 5'($urandom); dead = 5'($urandom); dir = 5'($urandom);
            cyc(1'b0);
            chk_bundle("no-tick hold", dut_bundle(), snap);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
